hilo_unit: RTL and testbench
============================

// Module: hilo_unit
// PURPOSE
//   Parametrised HI/LO register pair for the mult/div path. It holds the full
//   product/quotient/remainder written by the mult/div unit. It also serves
//   mthi/mtlo writes and mfhi/mflo reads, and raises a stall while a result is
//   outstanding. It sits between the mult/div unit and the MemtoReg write-back mux.
// PARAMETERS
//   DATA_W   32   width of HI, LO, result and read/write data buses
// PORTS
//   clk        in   1       clock; all state updates on rising edge
//   reset_n    in   1       asynchronous, active-low reset
//   op_start   in   1       mult/div issued; marks HI/LO pending
//   abort      in   1       cancel outstanding op (exception/flush)
//   res_valid  in   1       mult/div result present this cycle
//   res_hi     in   DATA_W  result high word (remainder for div)
//   res_lo     in   DATA_W  result low word (quotient for div)
//   mthi_en    in   1       write mt_data to HI
//   mtlo_en    in   1       write mt_data to LO
//   mt_data    in   DATA_W  mthi/mtlo write data
//   rd_hi_req  in   1       mfhi read request
//   rd_lo_req  in   1       mflo read request
//   rd_data    out  DATA_W  read data to the MemtoReg mux
//   rd_valid   out  1       rd_data is valid this cycle
//   stall      out  1       hold the issuing instruction
//   busy       out  1       result outstanding (state == PENDING)
//   proto_err  out  1       sticky protocol-violation flag
//   hi_q       out  DATA_W  current HI
//   lo_q       out  DATA_W  current LO
// BEHAVIOUR
//   - Reset (async, reset_n=0): hi_q=lo_q=0, state=IDLE, busy=0, proto_err=0.
//     Reset mid-op discards the pending result.
//   - FSM states: IDLE, PENDING; busy = (state==PENDING).
//     IDLE    & op_start                 -> PENDING
//     PENDING & abort                    -> IDLE, no write; abort beats res_valid
//     PENDING & res_valid & ~abort       -> HI<=res_hi, LO<=res_lo at edge;
//                                           -> PENDING if op_start same cycle,
//                                           else -> IDLE
//     PENDING & op_start & ~res_valid    -> ignored, proto_err<=1
//     IDLE    & res_valid                -> ignored, proto_err<=1
//   - stall = busy & (rd_hi_req|rd_lo_req|mthi_en|mtlo_en)
//     (see the HILO_BYPASS_EN exception below).
//   - mthi/mtlo write at the next edge only when not stalled. Both enables may
//     be set: both HI and LO take mt_data. In IDLE with op_start in the same
//     cycle, the mt write still happens and state -> PENDING.
//   - Reads are combinational from the registers:
//     rd_data = rd_hi_req ? hi_q : lo_q (HI wins if both requested).
//     rd_valid = (rd_hi_req|rd_lo_req) & ~stall.
//     When no read is requested, rd_data = 0.
//   - A read in the same cycle as a write returns the old value (0-cycle read).
//     The new value is visible the next cycle.
//   - No width truncation: full DATA_W stored and returned.
// CONFIGURATION
//   HILO_BYPASS_EN defined: in PENDING with res_valid & ~abort, reads are not
//     stalled. rd_data = res_hi/res_lo (forwarded) and rd_valid=1. mt writes
//     still stall that cycle.
//   Not defined: every read in PENDING stalls, including the res_valid cycle.
//     The read completes the cycle after the result is written.
// TESTING
//   1 reset_n=0 mid-PENDING -> hi_q=lo_q=0, busy=0, proto_err=0 immediately
//   2 op_start; 3 idle cycles; res_valid, res_hi=32'hDEAD_BEEF,
//     res_lo=32'h0000_1234 -> busy 1 for 4 cycles, then hi_q/lo_q updated, busy=0
//   3 rd_lo_req held from op_start -> stall=1 until result; without bypass
//     rd_data=32'h0000_1234 one cycle after res_valid; with bypass on the
//     res_valid cycle
//   4 PENDING, abort & res_valid same cycle -> HI/LO unchanged, state IDLE;
//     res_valid next cycle -> proto_err=1
//   5 IDLE, mthi_en & mtlo_en, mt_data=32'hA5A5_A5A5, rd_hi_req same cycle ->
//     rd_data=old HI, next cycle hi_q=lo_q=32'hA5A5_A5A5
//   6 PENDING, res_valid & op_start same cycle -> registers written, busy stays 1

Source files
------------

// File: rtl/hilo_unit.sv
// hilo_unit: HI/LO register pair for the mult/div path.
// Holds the mult/div result and serves mthi/mtlo writes and mfhi/mflo reads.
// Raises stall while a result is outstanding.
// Optional feature: define HILO_BYPASS_EN to forward the arriving result to
// reads in the cycle it is written, instead of stalling those reads.
module hilo_unit #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              op_start,
  input  logic              abort,
  input  logic              res_valid,
  input  logic [DATA_W-1:0] res_hi,
  input  logic [DATA_W-1:0] res_lo,
  input  logic              mthi_en,
  input  logic              mtlo_en,
  input  logic [DATA_W-1:0] mt_data,
  input  logic              rd_hi_req,
  input  logic              rd_lo_req,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              stall,
  output logic              busy,
  output logic              proto_err,
  output logic [DATA_W-1:0] hi_q,
  output logic [DATA_W-1:0] lo_q
);

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic read_req;
  logic mt_req;
  logic result_take;   // result accepted into HI/LO at this edge
  logic hi_mt_wr;
  logic lo_mt_wr;
  logic proto_viol;

  assign read_req = rd_hi_req | rd_lo_req;
  assign mt_req   = mthi_en | mtlo_en;

  // State register: IDLE until an op issues, PENDING while the result is owed.
  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic: abort beats an arriving result; op_start back-to-back
  // with the result keeps the unit pending.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (op_start) state_nxt = PENDING;
      end
      PENDING: begin
        if (abort)          state_nxt = IDLE;
        else if (res_valid) state_nxt = op_start ? PENDING : IDLE;
      end
    endcase
  end

  // Output logic: busy/stall/read path and the write enables derived from them.
  always_comb begin
    busy        = (state == PENDING);
    result_take = busy & res_valid & ~abort;
`ifdef HILO_BYPASS_EN
    // Reads in the result cycle are served from the forwarded result.
    stall       = busy & (mt_req | (read_req & ~result_take));
`else
    stall       = busy & (mt_req | read_req);
`endif
    rd_valid    = read_req & ~stall;
    rd_data     = '0;
    if (read_req) begin
`ifdef HILO_BYPASS_EN
      if (result_take) rd_data = rd_hi_req ? res_hi : res_lo;
      else             rd_data = rd_hi_req ? hi_q : lo_q;
`else
      rd_data = rd_hi_req ? hi_q : lo_q;
`endif
    end
    hi_mt_wr    = mthi_en & ~stall;
    lo_mt_wr    = mtlo_en & ~stall;
    proto_viol  = (busy & op_start & ~res_valid & ~abort) | (~busy & res_valid);
  end

  // HI/LO registers: result writes happen only in PENDING and mt writes only
  // when unstalled (i.e. IDLE), so the two sources never collide.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (result_take) begin
      hi_q <= res_hi;
      lo_q <= res_lo;
    end else begin
      if (hi_mt_wr) hi_q <= mt_data;
      if (lo_mt_wr) lo_q <= mt_data;
    end
  end

  // Sticky protocol-violation flag: cleared only by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        proto_err <= 1'b0;
    else if (proto_viol) proto_err <= 1'b1;
  end

endmodule

// File: tb/tb_hilo_unit.sv
// tb_hilo_unit: table-driven vectors plus hand sequences for hilo_unit.
// Read results go through a scoreboard queue popped by a monitor whenever
// rd_valid is observed. Honours HILO_BYPASS_EN the same way as the design.
module tb_hilo_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         op_start, abort, res_valid;
  logic [W-1:0] res_hi, res_lo;
  logic         mthi_en, mtlo_en;
  logic [W-1:0] mt_data;
  logic         rd_hi_req, rd_lo_req;
  logic [W-1:0] rd_data;
  logic         rd_valid, stall, busy, proto_err;
  logic [W-1:0] hi_q, lo_q;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    string        name;
    logic         op;
    logic         res;
    logic [W-1:0] rh;
    logic [W-1:0] rl;
    logic         mh;
    logic         ml;
    logic [W-1:0] md;
    logic         rdh;
    logic         rdl;
    logic         e_stall;
    logic         e_rv;
    logic [W-1:0] e_rd;
    logic [W-1:0] e_hi;
    logic [W-1:0] e_lo;
    logic         e_busy;
    logic         e_perr;
  } vec_t;

  vec_t vecs[10];

  hilo_unit #(.DATA_W(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .op_start  (op_start),
    .abort     (abort),
    .res_valid (res_valid),
    .res_hi    (res_hi),
    .res_lo    (res_lo),
    .mthi_en   (mthi_en),
    .mtlo_en   (mtlo_en),
    .mt_data   (mt_data),
    .rd_hi_req (rd_hi_req),
    .rd_lo_req (rd_lo_req),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .stall     (stall),
    .busy      (busy),
    .proto_err (proto_err),
    .hi_q      (hi_q),
    .lo_q      (lo_q)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] b2w(input logic b);
    return {{(W-1){1'b0}}, b};
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: every accepted read pops the oldest expected value.
  always @(negedge clk) begin
    #4;
    if (reset_n === 1'b1 && rd_valid === 1'b1) begin
      if (exp_q.size() > 0) check("rd_data_sb", rd_data, exp_q.pop_front());
      else                  check("rd_valid_unexpected", b2w(rd_valid), b2w(1'b0));
    end
  end

  task automatic clr();
    op_start  = 1'b0;
    abort     = 1'b0;
    res_valid = 1'b0;
    res_hi    = '0;
    res_lo    = '0;
    mthi_en   = 1'b0;
    mtlo_en   = 1'b0;
    mt_data   = '0;
    rd_hi_req = 1'b0;
    rd_lo_req = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr();
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic check_regs(input string tag, input logic [W-1:0] e_hi, input logic [W-1:0] e_lo,
                            input logic e_busy, input logic e_perr);
    check({tag, ".hi_q"}, hi_q, e_hi);
    check({tag, ".lo_q"}, lo_q, e_lo);
    check({tag, ".busy"}, b2w(busy), b2w(e_busy));
    check({tag, ".proto_err"}, b2w(proto_err), b2w(e_perr));
  endtask

  function automatic vec_t mk(input string n, input logic op, input logic res,
                              input logic [W-1:0] rh, input logic [W-1:0] rl,
                              input logic mh, input logic ml, input logic [W-1:0] md,
                              input logic rdh, input logic rdl,
                              input logic e_stall, input logic e_rv, input logic [W-1:0] e_rd,
                              input logic [W-1:0] e_hi, input logic [W-1:0] e_lo,
                              input logic e_busy, input logic e_perr);
    vec_t v;
    v.name = n; v.op = op; v.res = res; v.rh = rh; v.rl = rl;
    v.mh = mh; v.ml = ml; v.md = md; v.rdh = rdh; v.rdl = rdl;
    v.e_stall = e_stall; v.e_rv = e_rv; v.e_rd = e_rd;
    v.e_hi = e_hi; v.e_lo = e_lo; v.e_busy = e_busy; v.e_perr = e_perr;
    return v;
  endfunction

  task automatic apply_row(input vec_t v);
    @(negedge clk);
    clr();
    op_start  = v.op;
    res_valid = v.res;
    res_hi    = v.rh;
    res_lo    = v.rl;
    mthi_en   = v.mh;
    mtlo_en   = v.ml;
    mt_data   = v.md;
    rd_hi_req = v.rdh;
    rd_lo_req = v.rdl;
    #2;
    check({v.name, ".stall"}, b2w(stall), b2w(v.e_stall));
    check({v.name, ".rd_valid"}, b2w(rd_valid), b2w(v.e_rv));
    if (v.e_rv) exp_q.push_back(v.e_rd);
    else if (!(v.rdh || v.rdl)) check({v.name, ".rd_data_idle"}, rd_data, v.e_rd);
    @(posedge clk);
    #1;
    check_regs(v.name, v.e_hi, v.e_lo, v.e_busy, v.e_perr);
  endtask

  initial begin
    clr();
    //            name            op res rh            rl            mh ml md            rdh rdl st rv rd            hi            lo            busy perr
    vecs[0] = mk("mthi",          0, 0, '0,           '0,           1, 0, 32'h1111_1111, 0, 0, 0, 0, '0,           32'h1111_1111, 32'h0,        0, 0);
    vecs[1] = mk("mtlo_rdhi",     0, 0, '0,           '0,           0, 1, 32'h2222_2222, 1, 0, 0, 1, 32'h1111_1111, 32'h1111_1111, 32'h2222_2222, 0, 0);
    vecs[2] = mk("rd_both",       0, 0, '0,           '0,           0, 0, '0,           1, 1, 0, 1, 32'h1111_1111, 32'h1111_1111, 32'h2222_2222, 0, 0);
    vecs[3] = mk("rd_lo",         0, 0, '0,           '0,           0, 0, '0,           0, 1, 0, 1, 32'h2222_2222, 32'h1111_1111, 32'h2222_2222, 0, 0);
    vecs[4] = mk("mt_both_rdhi",  0, 0, '0,           '0,           1, 1, 32'hA5A5_A5A5, 1, 0, 0, 1, 32'h1111_1111, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 0, 0);
    vecs[5] = mk("op_start_mthi", 1, 0, '0,           '0,           1, 0, 32'h3333_3333, 0, 0, 0, 0, '0,           32'h3333_3333, 32'hA5A5_A5A5, 1, 0);
    vecs[6] = mk("pend_mt_stall", 0, 0, '0,           '0,           0, 1, 32'hFFFF_FFFF, 0, 0, 1, 0, '0,           32'h3333_3333, 32'hA5A5_A5A5, 1, 0);
    vecs[7] = mk("pend_rd_stall", 0, 0, '0,           '0,           0, 0, '0,           1, 0, 1, 0, '0,           32'h3333_3333, 32'hA5A5_A5A5, 1, 0);
    vecs[8] = mk("pend_result",   0, 1, 32'hCAFE_0001, 32'h0BAD_0002, 0, 0, '0,           0, 0, 0, 0, '0,           32'hCAFE_0001, 32'h0BAD_0002, 0, 0);
    vecs[9] = mk("idle_res_err",  0, 1, 32'hFFFF_0000, 32'h0000_FFFF, 0, 0, '0,           0, 0, 0, 0, '0,           32'hCAFE_0001, 32'h0BAD_0002, 0, 1);

    // Reset values.
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #2;
    check_regs("reset", '0, '0, 1'b0, 1'b0);
    check("reset.stall", b2w(stall), b2w(1'b0));
    check("reset.rd_data", rd_data, '0);

    for (int i = 0; i < 10; i++) apply_row(vecs[i]);

    // Asynchronous reset in the middle of PENDING clears everything at once.
    @(negedge clk);
    clr();
    op_start = 1'b1;
    @(posedge clk);
    #1;
    check("arst.busy_before", b2w(busy), b2w(1'b1));
    @(negedge clk);
    clr();
    #2;
    reset_n = 1'b0;
    #1;
    check_regs("arst", '0, '0, 1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    // Long op: busy for four cycles, rd_lo_req held from the first PENDING cycle.
    @(negedge clk);
    clr();
    op_start = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      clr();
      rd_lo_req = 1'b1;
      #2;
      check($sformatf("long.c%0d.busy", c), b2w(busy), b2w(1'b1));
      check($sformatf("long.c%0d.stall", c), b2w(stall), b2w(1'b1));
      check($sformatf("long.c%0d.rd_valid", c), b2w(rd_valid), b2w(1'b0));
    end
    @(negedge clk);
    clr();
    rd_lo_req = 1'b1;
    res_valid = 1'b1;
    res_hi    = 32'hDEAD_BEEF;
    res_lo    = 32'h0000_1234;
    #2;
    check("long.c4.busy", b2w(busy), b2w(1'b1));
`ifdef HILO_BYPASS_EN
    check("long.c4.stall", b2w(stall), b2w(1'b0));
    check("long.c4.rd_valid", b2w(rd_valid), b2w(1'b1));
    exp_q.push_back(32'h0000_1234);
`else
    check("long.c4.stall", b2w(stall), b2w(1'b1));
    check("long.c4.rd_valid", b2w(rd_valid), b2w(1'b0));
`endif
    @(posedge clk);
    #1;
    check_regs("long.done", 32'hDEAD_BEEF, 32'h0000_1234, 1'b0, 1'b0);
    @(negedge clk);
    clr();
`ifndef HILO_BYPASS_EN
    rd_lo_req = 1'b1;
    #2;
    check("long.c5.stall", b2w(stall), b2w(1'b0));
    check("long.c5.rd_valid", b2w(rd_valid), b2w(1'b1));
    exp_q.push_back(32'h0000_1234);
`endif
    @(posedge clk);
    #1;

    // Result and a new op_start in the same cycle keep the unit busy.
    @(negedge clk);
    clr();
    op_start = 1'b1;
    @(negedge clk);
    clr();
    op_start  = 1'b1;
    res_valid = 1'b1;
    res_hi    = 32'h1234_5678;
    res_lo    = 32'h9ABC_DEF0;
    @(posedge clk);
    #1;
    check_regs("b2b.first", 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0);
    @(negedge clk);
    clr();
    res_valid = 1'b1;
    res_hi    = 32'h0F0F_0F0F;
    res_lo    = 32'hF0F0_F0F0;
    @(posedge clk);
    #1;
    check_regs("b2b.second", 32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b0, 1'b0);

    // Abort beats a simultaneous result; a late result is a protocol error.
    @(negedge clk);
    clr();
    op_start = 1'b1;
    @(negedge clk);
    clr();
    abort     = 1'b1;
    res_valid = 1'b1;
    res_hi    = 32'h5555_5555;
    res_lo    = 32'h6666_6666;
    @(posedge clk);
    #1;
    check_regs("abort", 32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b0, 1'b0);
    @(negedge clk);
    clr();
    res_valid = 1'b1;
    res_hi    = 32'h7777_7777;
    res_lo    = 32'h8888_8888;
    @(posedge clk);
    #1;
    check_regs("late_res", 32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b0, 1'b1);

    // A second op_start while pending is ignored and flagged.
    do_reset();
    @(negedge clk);
    clr();
    op_start = 1'b1;
    @(negedge clk);
    clr();
    op_start = 1'b1;
    @(posedge clk);
    #1;
    check_regs("dup_start", '0, '0, 1'b1, 1'b1);

    @(negedge clk);
    clr();
    #6;
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
